fuzz_campaign_ctrl: RTL and testbench
=====================================

# fuzz_campaign_ctrl

Campaign sequencer for the satellite fuzzer engine. It runs the learning phase by counting functional-bus seed captures, then enables mutation. It meters iterations against a budget and coverage target, and decides the campaign outcome on hang, abort, budget exhaustion or coverage reached. It sits between the software config/status registers and the fuzzer's `mut_en`, soft-reset and alarm/coverage signals.

## Interface
- `POOL_DEPTH`, 16: seed captures required before mutation may start.
- `DRAIN_LIMIT`, 1024: max cycles to wait for an in-flight IP response after stop is decided.
- `RECOVER_CYCLES`, 4: fuzzer soft-reset pulse length (recovery feature only).
- `MAX_RECOVERIES`, 8: hangs tolerated before the campaign ends (recovery feature only).

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `cfg_start` in 1: pulse; starts a campaign from IDLE or DONE.
- `cfg_abort` in 1: pulse; ends the campaign from any active state.
- `cfg_iter_budget` in 32: iteration limit; 0 = unlimited.
- `cfg_cov_target` in 8: coverage percent stop; 0 = disabled.
- `bus_start_obs` in 1: functional-bus start (seed capture event).
- `fuzz_start_obs` in 1: fuzzer→IP start pulse (one iteration).
- `ip_valid_obs` in 1: IP→fuzzer response valid.
- `fuzz_alarm_hang` in 1: fuzzer watchdog alarm (sticky).
- `fuzz_alarm_collision` in 1: fuzzer collision alarm.
- `fuzz_coverage` in 8: fuzzer coverage score 0–100.
- `fuzz_mut_en` out 1: mutation enable to the fuzzer.
- `fuzz_soft_rst_n` out 1: active-low soft reset to the fuzzer.
- `ctrl_state` out 3: current FSM state encoding.
- `iter_count` out 32: iterations this campaign, saturating.
- `seed_count` out 8: seeds captured in LEARN, saturates at `POOL_DEPTH`.
- `hang_count` out 8: hangs this campaign.
- `collision_count` out 16: collision-alarm rising edges, saturating.
- `done` out 1: level; campaign finished.
- `done_reason` out 2: 0 BUDGET, 1 COVERAGE, 2 HANG, 3 ABORT.

## Operation
- States and encodings: IDLE(0), LEARN(1), FUZZ(2), DRAIN(3), RECOVER(4), DONE(5).
- IDLE/DONE + `cfg_start` → LEARN:
  - clear all counters, `done`, `done_reason`.
- LEARN:
  - each `bus_start_obs` increments `seed_count`.
  - on the cycle `seed_count` reaches `POOL_DEPTH` → FUZZ.
- FUZZ:
  - `fuzz_mut_en`=1.
  - each `fuzz_start_obs` increments `iter_count`.
  - Stop when `iter_count` == budget (budget≠0) → DRAIN, reason BUDGET.
  - Stop when `fuzz_coverage` ≥ target (target≠0) → DRAIN, reason COVERAGE.
  - Targets >100 are never met.
- DRAIN:
  - `fuzz_mut_en`=0.
  - wait for `ip_valid_obs`, or `DRAIN_LIMIT` cycles, whichever comes first → DONE.
  - An iteration already issued (start seen with no valid since) is always drained. If none is outstanding, go to DONE the next cycle.
- Hang (rising edge of `fuzz_alarm_hang` in FUZZ/DRAIN):
  - `hang_count`++.
  - handling depends on `FUZZ_HANG_RECOVER_EN` (see Configuration).
- `cfg_abort` in LEARN/FUZZ/DRAIN/RECOVER → DONE, reason ABORT.
- Simultaneous events, priority: abort > hang > coverage > budget.
- `collision_count` increments on each rising edge of `fuzz_alarm_collision` in any state; it is informational only.
- `cfg_start` outside IDLE/DONE is ignored.

## Timing
- All outputs are registered; every transition takes effect the cycle after its cause.
- Reset values:
  - state IDLE; `fuzz_mut_en`=0; `fuzz_soft_rst_n`=0 while `rst_n` low, 1 on the first clock after release.
  - all counts 0; `done`=0; `done_reason`=0.
- `fuzz_mut_en` rises 1 cycle after entering FUZZ and falls in the same cycle the state leaves FUZZ.
- `iter_count` and `seed_count` update 1 cycle after their strobe. The budget compare uses the updated count, so exactly `cfg_iter_budget` starts are counted.
- Reset mid-campaign: immediate return to reset values; no drain.

## Configuration
- `FUZZ_HANG_RECOVER_EN` defined:
  - hang → RECOVER.
  - drive `fuzz_soft_rst_n`=0 for `RECOVER_CYCLES` cycles → LEARN, with `seed_count` cleared; `iter_count` is kept.
  - When `hang_count` reaches `MAX_RECOVERIES` → DONE, reason HANG.
- Undefined:
  - hang → DONE, reason HANG.
  - RECOVER is unreachable; `fuzz_soft_rst_n` stays 1 after reset.

## Structure
- Shared package `fuzz_pkg` holds:
  - `ctrl_state_t` enum.
  - `done_reason_t` enum (BUDGET/COVERAGE/HANG/ABORT).
  - `COV_MAX`=100.
- One sub-module: `sat_counter` (parameterised width; clear, increment, saturate), instantiated for iteration, seed, hang and collision counts.

## Test plan
- Seed phase: reset, `cfg_start`, 16 `bus_start_obs` pulses → FUZZ; `fuzz_mut_en`=1 exactly 1 cycle after the 16th pulse is counted.
- Budget stop: budget=5, 5 `fuzz_start_obs` pulses, valid 10 cycles later → `iter_count`=5, DONE, `done_reason`=0.
- Coverage stop: target=80, `fuzz_coverage` stepped 79→80 → `fuzz_mut_en` falls next cycle, `done_reason`=1.
- Drain timeout: budget=1, start with no valid → DONE after 1024 cycles in DRAIN.
- Priority: same-cycle `cfg_abort` and hang edge → `done_reason`=3, `hang_count`=1.
- Recovery (macro on): hang → `fuzz_soft_rst_n` low 4 cycles, LEARN, `seed_count`=0; the 8th hang → DONE, `done_reason`=2.

Source files
------------

// File: rtl/fuzz_campaign_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fuzz_pkg
// Shared types and constants for the fuzz campaign controller.
//   ctrl_state_t  : controller FSM state encoding (drives ctrl_state)
//   done_reason_t : campaign outcome code (drives done_reason)
//   COV_MAX       : highest meaningful coverage score; targets above it never hit
//   cov_met()     : coverage-stop predicate
// -----------------------------------------------------------------------------
package fuzz_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LEARN   = 3'd1,
    S_FUZZ    = 3'd2,
    S_DRAIN   = 3'd3,
    S_RECOVER = 3'd4,
    S_DONE    = 3'd5
  } ctrl_state_t;

  typedef enum logic [1:0] {
    BUDGET   = 2'd0,
    COVERAGE = 2'd1,
    HANG     = 2'd2,
    ABORT    = 2'd3
  } done_reason_t;

  localparam logic [7:0] COV_MAX = 8'd100;

  // A zero target disables the stop; a target above COV_MAX can never be met.
  function automatic logic cov_met(input logic [7:0] cov, input logic [7:0] tgt);
    return (tgt != 8'd0) && (tgt <= COV_MAX) && (cov >= tgt);
  endfunction

endpackage

// File: rtl/fuzz_campaign_ctrl_if.sv
// -----------------------------------------------------------------------------
// fuzz_campaign_ctrl_if
// Bundles the software config/status registers and the fuzzer observation and
// control signals around the campaign controller.
//   master : software/fuzzer side (drives cfg_* and *_obs / fuzz_alarm_* inputs)
//   slave  : controller side (drives fuzz_mut_en, fuzz_soft_rst_n and status)
// -----------------------------------------------------------------------------
interface fuzz_campaign_ctrl_if;
  // Software config
  logic        cfg_start;
  logic        cfg_abort;
  logic [31:0] cfg_iter_budget;
  logic [7:0]  cfg_cov_target;
  // Observed fuzzer/bus activity
  logic        bus_start_obs;
  logic        fuzz_start_obs;
  logic        ip_valid_obs;
  logic        fuzz_alarm_hang;
  logic        fuzz_alarm_collision;
  logic [7:0]  fuzz_coverage;
  // Fuzzer control
  logic        fuzz_mut_en;
  logic        fuzz_soft_rst_n;
  // Status
  logic [2:0]  ctrl_state;
  logic [31:0] iter_count;
  logic [7:0]  seed_count;
  logic [7:0]  hang_count;
  logic [15:0] collision_count;
  logic        done;
  logic [1:0]  done_reason;

  modport master (
    output cfg_start, cfg_abort, cfg_iter_budget, cfg_cov_target,
           bus_start_obs, fuzz_start_obs, ip_valid_obs,
           fuzz_alarm_hang, fuzz_alarm_collision, fuzz_coverage,
    input  fuzz_mut_en, fuzz_soft_rst_n, ctrl_state, iter_count, seed_count,
           hang_count, collision_count, done, done_reason
  );

  modport slave (
    input  cfg_start, cfg_abort, cfg_iter_budget, cfg_cov_target,
           bus_start_obs, fuzz_start_obs, ip_valid_obs,
           fuzz_alarm_hang, fuzz_alarm_collision, fuzz_coverage,
    output fuzz_mut_en, fuzz_soft_rst_n, ctrl_state, iter_count, seed_count,
           hang_count, collision_count, done, done_reason
  );
endinterface

// File: rtl/fuzz_campaign_ctrl_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter with synchronous clear that holds at MAX instead of wrapping.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_clr      : synchronous clear (wins over i_inc)
//   i_inc      : increment strobe
//   o_count    : registered count
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] MAX   = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  // NOTE: sequential state uses <= so every flop samples pre-edge values;
  // a blocking = here would let later statements see the new value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count < MAX)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/fuzz_campaign_ctrl.sv
// -----------------------------------------------------------------------------
// fuzz_campaign_ctrl
// Campaign sequencer for the fuzzer: counts seed captures in LEARN, enables
// mutation in FUZZ, meters iterations against budget/coverage, drains the last
// in-flight IP response and records the campaign outcome.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : fuzz_campaign_ctrl_if.slave (config, observations, status)
// Build option: FUZZ_HANG_RECOVER_EN -- a hang soft-resets the fuzzer and
// relearns seeds (up to MAX_RECOVERIES hangs) instead of ending the campaign.
// -----------------------------------------------------------------------------
module fuzz_campaign_ctrl
  import fuzz_pkg::*;
#(
  parameter int unsigned POOL_DEPTH     = 16,
  parameter int unsigned DRAIN_LIMIT    = 1024,
  parameter int unsigned RECOVER_CYCLES = 4,
  parameter int unsigned MAX_RECOVERIES = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  fuzz_campaign_ctrl_if.slave bus
);

`ifdef FUZZ_HANG_RECOVER_EN
  localparam bit RECOVER_EN = 1'b1;
`else
  localparam bit RECOVER_EN = 1'b0;
`endif

  localparam int unsigned DRAIN_W = $clog2(DRAIN_LIMIT) + 1;
  localparam int unsigned RCV_W   = $clog2(RECOVER_CYCLES) + 1;

  ctrl_state_t  r_state, w_next;
  done_reason_t r_done_reason, r_pend_reason, w_reason_nxt;
  logic         r_mut_en, r_soft_rst_n, r_done;
  logic         r_outstanding, r_hang_d, r_coll_d;
  logic [DRAIN_W-1:0] r_drain_cnt;
  logic [RCV_W-1:0]   r_rcv_cnt;

  logic [31:0] w_iter_count;
  logic [7:0]  w_seed_count, w_hang_count;
  logic [15:0] w_coll_count;

  logic        w_campaign_start, w_hang_rise, w_hang_evt, w_coll_rise;
  logic        w_iter_inc, w_seed_inc, w_budget_hit, w_cov_hit, w_last_seed;
  logic        w_drain_done, w_rcv_done, w_hang_to_done;
  logic [32:0] w_iter_next;

  assign w_campaign_start = ((r_state == S_IDLE) || (r_state == S_DONE)) && bus.cfg_start;
  assign w_hang_rise      = bus.fuzz_alarm_hang & ~r_hang_d;
  assign w_hang_evt       = w_hang_rise && ((r_state == S_FUZZ) || (r_state == S_DRAIN));
  assign w_coll_rise      = bus.fuzz_alarm_collision & ~r_coll_d;
  assign w_iter_inc       = (r_state == S_FUZZ) && bus.fuzz_start_obs;
  assign w_seed_inc       = (r_state == S_LEARN) && bus.bus_start_obs;

  // Budget is compared against the post-increment count so the stop lands on
  // the same edge that counts the last allowed start. 33 bits avoid wrap when
  // the counter sits saturated.
  assign w_iter_next  = {1'b0, w_iter_count} + {32'd0, w_iter_inc};
  assign w_budget_hit = (bus.cfg_iter_budget != 32'd0) &&
                        (w_iter_next >= {1'b0, bus.cfg_iter_budget});
  assign w_cov_hit    = cov_met(bus.fuzz_coverage, bus.cfg_cov_target);
  assign w_last_seed  = w_seed_inc && (w_seed_count >= 8'(POOL_DEPTH - 1));

  // Nothing in flight means there is nothing to wait for.
  assign w_drain_done = bus.ip_valid_obs || !r_outstanding ||
                        (r_drain_cnt == DRAIN_W'(DRAIN_LIMIT - 1));
  assign w_rcv_done   = (r_rcv_cnt == RCV_W'(RECOVER_CYCLES - 1));

  // This hang is the one that exhausts the recovery allowance.
  assign w_hang_to_done = !RECOVER_EN || (w_hang_count >= 8'(MAX_RECOVERIES - 1));

  // NOTE: next-state and reason get defaults first so every path assigns
  // them; a missing branch would otherwise infer a latch.
  always_comb begin
    w_next       = r_state;
    w_reason_nxt = r_pend_reason;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.cfg_start) begin
          w_next       = S_LEARN;
          w_reason_nxt = BUDGET;
        end
      end
      S_LEARN: begin
        if (bus.cfg_abort) begin
          w_next       = S_DONE;
          w_reason_nxt = ABORT;
        end else if (w_last_seed) begin
          w_next = S_FUZZ;
        end
      end
      S_FUZZ: begin
        if (bus.cfg_abort) begin
          w_next       = S_DONE;
          w_reason_nxt = ABORT;
        end else if (w_hang_evt) begin
          if (w_hang_to_done) begin
            w_next       = S_DONE;
            w_reason_nxt = HANG;
          end else begin
            w_next = S_RECOVER;
          end
        end else if (w_cov_hit) begin
          w_next       = S_DRAIN;
          w_reason_nxt = COVERAGE;
        end else if (w_budget_hit) begin
          w_next       = S_DRAIN;
          w_reason_nxt = BUDGET;
        end
      end
      S_DRAIN: begin
        if (bus.cfg_abort) begin
          w_next       = S_DONE;
          w_reason_nxt = ABORT;
        end else if (w_hang_evt) begin
          if (w_hang_to_done) begin
            w_next       = S_DONE;
            w_reason_nxt = HANG;
          end else begin
            w_next = S_RECOVER;
          end
        end else if (w_drain_done) begin
          w_next = S_DONE;
        end
      end
      S_RECOVER: begin
        if (bus.cfg_abort) begin
          w_next       = S_DONE;
          w_reason_nxt = ABORT;
        end else if (w_rcv_done) begin
          w_next = S_LEARN;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_mut_en      <= 1'b0;
      r_soft_rst_n  <= 1'b0;
      r_done        <= 1'b0;
      r_done_reason <= BUDGET;
      r_pend_reason <= BUDGET;
      r_outstanding <= 1'b0;
      r_hang_d      <= 1'b0;
      r_coll_d      <= 1'b0;
      r_drain_cnt   <= '0;
      r_rcv_cnt     <= '0;
    end else begin
      r_state       <= w_next;
      // High only from the second FUZZ cycle; drops on the edge leaving FUZZ.
      r_mut_en      <= (r_state == S_FUZZ) && (w_next == S_FUZZ);
      r_soft_rst_n  <= (w_next != S_RECOVER);
      r_pend_reason <= w_reason_nxt;
      r_hang_d      <= bus.fuzz_alarm_hang;
      r_coll_d      <= bus.fuzz_alarm_collision;

      if (w_campaign_start) begin
        r_done        <= 1'b0;
        r_done_reason <= BUDGET;
      end else if ((w_next == S_DONE) && (r_state != S_DONE)) begin
        r_done        <= 1'b1;
        r_done_reason <= w_reason_nxt;
      end

      // A start opens an iteration, a valid closes the previous one.
      if (w_campaign_start) begin
        r_outstanding <= 1'b0;
      end else begin
        r_outstanding <= bus.fuzz_start_obs | (r_outstanding & ~bus.ip_valid_obs);
      end

      r_drain_cnt <= (r_state == S_DRAIN)   ? r_drain_cnt + 1'b1 : '0;
      r_rcv_cnt   <= (r_state == S_RECOVER) ? r_rcv_cnt + 1'b1   : '0;
    end
  end

  sat_counter #(.WIDTH(32)) u_iter_cnt (
    .clk(clk), .rst_n(rst_n), .i_clr(w_campaign_start),
    .i_inc(w_iter_inc), .o_count(w_iter_count)
  );

  sat_counter #(.WIDTH(8), .MAX(8'(POOL_DEPTH))) u_seed_cnt (
    .clk(clk), .rst_n(rst_n), .i_clr(w_campaign_start || (r_state == S_RECOVER)),
    .i_inc(w_seed_inc), .o_count(w_seed_count)
  );

  sat_counter #(.WIDTH(8)) u_hang_cnt (
    .clk(clk), .rst_n(rst_n), .i_clr(w_campaign_start),
    .i_inc(w_hang_evt), .o_count(w_hang_count)
  );

  sat_counter #(.WIDTH(16)) u_coll_cnt (
    .clk(clk), .rst_n(rst_n), .i_clr(w_campaign_start),
    .i_inc(w_coll_rise), .o_count(w_coll_count)
  );

  assign bus.fuzz_mut_en     = r_mut_en;
  assign bus.fuzz_soft_rst_n = r_soft_rst_n;
  assign bus.ctrl_state      = r_state;
  assign bus.iter_count      = w_iter_count;
  assign bus.seed_count      = w_seed_count;
  assign bus.hang_count      = w_hang_count;
  assign bus.collision_count = w_coll_count;
  assign bus.done            = r_done;
  assign bus.done_reason     = r_done_reason;

endmodule

// File: tb/tb_fuzz_campaign_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fuzz_campaign_ctrl
// Directed bench for fuzz_campaign_ctrl: seed phase, budget stop, coverage
// stop, drain timeout, abort/hang priority, hang handling (both builds of
// FUZZ_HANG_RECOVER_EN), collision counting and asynchronous reset.
// Expected values are queued with sb_push() and consumed by check().
// -----------------------------------------------------------------------------
module tb_fuzz_campaign_ctrl;
  import fuzz_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fuzz_campaign_ctrl_if bus ();

  fuzz_campaign_ctrl #(
    .POOL_DEPTH(16), .DRAIN_LIMIT(1024), .RECOVER_CYCLES(4), .MAX_RECOVERIES(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  task automatic sb_push(input string tag, input logic [31:0] value);
    tag_q.push_back(tag);
    exp_q.push_back(value);
  endtask

  task automatic check(input logic [31:0] observed);
    logic [31:0] expected;
    string       tag;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty observed=%0d required=<none>", observed);
    end else begin
      expected = exp_q.pop_front();
      tag      = tag_q.pop_front();
      assert (observed === expected) else begin
        errors++;
        $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_campaign();
    bus.cfg_start = 1'b1;
    tick();
    bus.cfg_start = 1'b0;
  endtask

  task automatic learn_seeds(input int n);
    for (int i = 0; i < n; i++) begin
      bus.bus_start_obs = 1'b1;
      tick();
    end
    bus.bus_start_obs = 1'b0;
  endtask

  task automatic iter_pulse();
    bus.fuzz_start_obs = 1'b1;
    tick();
    bus.fuzz_start_obs = 1'b0;
  endtask

  // Reaches FUZZ with mutation enabled.
  task automatic go_fuzz();
    start_campaign();
    learn_seeds(16);
    tick();
  endtask

  initial begin
    int n;
    int lows;
    rst_n                    = 1'b0;
    bus.cfg_start            = 1'b0;
    bus.cfg_abort            = 1'b0;
    bus.cfg_iter_budget      = 32'd0;
    bus.cfg_cov_target       = 8'd0;
    bus.bus_start_obs        = 1'b0;
    bus.fuzz_start_obs       = 1'b0;
    bus.ip_valid_obs         = 1'b0;
    bus.fuzz_alarm_hang      = 1'b0;
    bus.fuzz_alarm_collision = 1'b0;
    bus.fuzz_coverage        = 8'd0;
    #12;

    // ---- reset values
    sb_push("rst_state", 32'd0);     check(32'(bus.ctrl_state));
    sb_push("rst_mut_en", 32'd0);    check(32'(bus.fuzz_mut_en));
    sb_push("rst_soft_rst_n", 32'd0); check(32'(bus.fuzz_soft_rst_n));
    sb_push("rst_iter", 32'd0);      check(bus.iter_count);
    sb_push("rst_seed", 32'd0);      check(32'(bus.seed_count));
    sb_push("rst_hang", 32'd0);      check(32'(bus.hang_count));
    sb_push("rst_coll", 32'd0);      check(32'(bus.collision_count));
    sb_push("rst_done", 32'd0);      check(32'(bus.done));
    sb_push("rst_reason", 32'd0);    check(32'(bus.done_reason));
    rst_n = 1'b1;
    tick();
    sb_push("soft_rst_release", 32'd1); check(32'(bus.fuzz_soft_rst_n));

    // ---- collision edges counted in IDLE; a held level counts once
    bus.fuzz_alarm_collision = 1'b1; tick(); tick();
    bus.fuzz_alarm_collision = 1'b0; tick();
    bus.fuzz_alarm_collision = 1'b1; tick();
    bus.fuzz_alarm_collision = 1'b0; tick();
    sb_push("coll_edges", 32'd2); check(32'(bus.collision_count));

    // ---- seed phase, stray cfg_start in LEARN is ignored
    bus.cfg_iter_budget = 32'd5;
    start_campaign();
    sb_push("learn_state", 32'd1); check(32'(bus.ctrl_state));
    sb_push("start_clr_coll", 32'd0); check(32'(bus.collision_count));
    learn_seeds(8);
    bus.cfg_start     = 1'b1;
    bus.bus_start_obs = 1'b1;
    tick();
    bus.cfg_start     = 1'b0;
    bus.bus_start_obs = 1'b0;
    sb_push("start_ignored_seed", 32'd9); check(32'(bus.seed_count));
    learn_seeds(7);
    sb_push("seed_full", 32'd16);   check(32'(bus.seed_count));
    sb_push("fuzz_state", 32'd2);   check(32'(bus.ctrl_state));
    sb_push("mut_en_lag", 32'd0);   check(32'(bus.fuzz_mut_en));
    tick();
    sb_push("mut_en_on", 32'd1);    check(32'(bus.fuzz_mut_en));

    // ---- budget stop at 5 starts, response 10 cycles later
    for (int i = 0; i < 4; i++) begin
      iter_pulse();
      tick();
    end
    sb_push("budget_iter4", 32'd4);  check(bus.iter_count);
    sb_push("budget_fuzz4", 32'd2);  check(32'(bus.ctrl_state));
    iter_pulse();
    sb_push("budget_iter5", 32'd5);  check(bus.iter_count);
    sb_push("budget_drain", 32'd3);  check(32'(bus.ctrl_state));
    sb_push("budget_mut_off", 32'd0); check(32'(bus.fuzz_mut_en));
    for (int i = 0; i < 9; i++) tick();
    sb_push("budget_waiting", 32'd3); check(32'(bus.ctrl_state));
    bus.ip_valid_obs = 1'b1; tick(); bus.ip_valid_obs = 1'b0;
    sb_push("budget_done_state", 32'd5); check(32'(bus.ctrl_state));
    sb_push("budget_done", 32'd1);       check(32'(bus.done));
    sb_push("budget_reason", 32'd0);     check(32'(bus.done_reason));
    sb_push("budget_iter_final", 32'd5); check(bus.iter_count);

    // ---- coverage stop at target 80
    bus.cfg_iter_budget = 32'd0;
    bus.cfg_cov_target  = 8'd80;
    start_campaign();
    sb_push("restart_done_clr", 32'd0); check(32'(bus.done));
    sb_push("restart_iter_clr", 32'd0); check(bus.iter_count);
    learn_seeds(16);
    tick();
    bus.fuzz_coverage = 8'd79; tick(); tick();
    sb_push("cov79_fuzz", 32'd2);  check(32'(bus.ctrl_state));
    sb_push("cov79_mut", 32'd1);   check(32'(bus.fuzz_mut_en));
    bus.fuzz_coverage = 8'd80; tick();
    sb_push("cov80_mut_off", 32'd0); check(32'(bus.fuzz_mut_en));
    sb_push("cov80_drain", 32'd3);   check(32'(bus.ctrl_state));
    tick();
    sb_push("cov_done_state", 32'd5); check(32'(bus.ctrl_state));
    sb_push("cov_reason", 32'd1);     check(32'(bus.done_reason));
    bus.fuzz_coverage  = 8'd0;
    bus.cfg_cov_target = 8'd0;

    // ---- drain timeout with one unanswered start
    bus.cfg_iter_budget = 32'd1;
    go_fuzz();
    iter_pulse();
    sb_push("to_drain", 32'd3); check(32'(bus.ctrl_state));
    n = 0;
    while ((bus.ctrl_state == 3'd3) && (n < 2000)) begin
      tick();
      n++;
    end
    sb_push("drain_cycles", 32'd1024); check(32'(n));
    sb_push("drain_to_done", 32'd5);  check(32'(bus.ctrl_state));
    sb_push("drain_reason", 32'd0);   check(32'(bus.done_reason));
    bus.cfg_iter_budget = 32'd0;

    // ---- abort beats a same-cycle hang edge; the hang is still counted
    go_fuzz();
    bus.cfg_abort       = 1'b1;
    bus.fuzz_alarm_hang = 1'b1;
    tick();
    bus.cfg_abort = 1'b0;
    sb_push("prio_state", 32'd5);  check(32'(bus.ctrl_state));
    sb_push("prio_reason", 32'd3); check(32'(bus.done_reason));
    sb_push("prio_hang", 32'd1);   check(32'(bus.hang_count));
    bus.fuzz_alarm_hang = 1'b0;
    tick();

`ifdef FUZZ_HANG_RECOVER_EN
    // ---- recovery: 7 soft-resets, the 8th hang ends the campaign
    go_fuzz();
    iter_pulse();
    for (int h = 1; h <= 8; h++) begin
      bus.fuzz_alarm_hang = 1'b1;
      tick();
      bus.fuzz_alarm_hang = 1'b0;
      if (h < 8) begin
        sb_push("rcv_state", 32'd4);      check(32'(bus.ctrl_state));
        sb_push("rcv_hang", 32'(h));      check(32'(bus.hang_count));
        lows = (bus.fuzz_soft_rst_n == 1'b0) ? 1 : 0;
        for (int i = 0; i < 10; i++) begin
          tick();
          if (bus.fuzz_soft_rst_n == 1'b0) lows++;
          else break;
        end
        sb_push("rcv_low_cycles", 32'd4); check(32'(lows));
        sb_push("rcv_learn", 32'd1);      check(32'(bus.ctrl_state));
        sb_push("rcv_seed_clr", 32'd0);   check(32'(bus.seed_count));
        sb_push("rcv_iter_kept", 32'd1);  check(bus.iter_count);
        learn_seeds(16);
        tick();
      end
    end
    sb_push("rcv_final_state", 32'd5);  check(32'(bus.ctrl_state));
    sb_push("rcv_final_reason", 32'd2); check(32'(bus.done_reason));
    sb_push("rcv_final_hang", 32'd8);   check(32'(bus.hang_count));
`else
    // ---- without recovery a hang ends the campaign at once
    go_fuzz();
    bus.fuzz_alarm_hang = 1'b1;
    tick();
    bus.fuzz_alarm_hang = 1'b0;
    sb_push("hang_state", 32'd5);   check(32'(bus.ctrl_state));
    sb_push("hang_reason", 32'd2);  check(32'(bus.done_reason));
    sb_push("hang_count", 32'd1);   check(32'(bus.hang_count));
    sb_push("hang_soft_rst", 32'd1); check(32'(bus.fuzz_soft_rst_n));
`endif
    tick();

    // ---- asynchronous reset mid-campaign
    start_campaign();
    learn_seeds(4);
    sb_push("pre_reset_seed", 32'd4); check(32'(bus.seed_count));
    rst_n = 1'b0;
    #1;
    sb_push("async_rst_state", 32'd0); check(32'(bus.ctrl_state));
    sb_push("async_rst_seed", 32'd0);  check(32'(bus.seed_count));
    sb_push("async_rst_soft", 32'd0);  check(32'(bus.fuzz_soft_rst_n));
    rst_n = 1'b1;
    tick();

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_leftover observed=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
